tli4970_emulator: RTL and testbench

- SPI slave that emulates the TLI4970 digital current sensor.
- It serialises a 16-bit sensor frame on MISO whenever our SPI master asserts chip select. The master drives CS low, clocks SCLK and samples MISO on the SCLK falling edge.
- Used for hardware-in-the-loop testing of the motor board and as the reusable sensor model in benches.
- It runs on the system clock and oversamples the asynchronous SPI lines.

---
 rtl/tli4970_pkg.sv | 49 ++++
 rtl/spi_input_sync.sv | 31 +++
 rtl/tli4970_emulator.sv | 121 ++++++++++++
 tb/tb_tli4970_emulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tli4970_pkg.sv
// Shared constants, state encoding and frame builder for the TLI4970 sensor emulator.
package tli4970_pkg;

  localparam int FRAME_W    = 16;
  localparam int STATUS_BIT = 15;
  localparam int PARITY_BIT = 14;
  localparam int OCD_BIT    = 13;
  localparam int RAW_W      = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Clamp to the 13-bit sensor range, add the offset, then fix bit 14 for even frame parity.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic                    is_status,
    input logic signed [15:0]      cur,
    input logic [RAW_W-1:0]        status_bits,
    input logic [RAW_W-1:0]        offset
  );
    logic signed [15:0]   clamped;
    logic                 ocd;
    logic [RAW_W-1:0]     raw;
    logic [FRAME_W-1:0]   f;
    clamped = cur;
    ocd     = 1'b0;
    if (cur > 16'sd4095) begin
      clamped = 16'sd4095;
      ocd     = 1'b1;
    end else if (cur < -16'sd4096) begin
      clamped = -16'sd4096;
      ocd     = 1'b1;
    end
    raw = clamped[RAW_W-1:0] + offset;
    f   = '0;
    if (is_status) begin
      f[STATUS_BIT]  = 1'b1;
      f[RAW_W-1:0]   = status_bits;
    end else begin
      f[OCD_BIT]     = ocd;
      f[RAW_W-1:0]   = raw;
    end
    f[PARITY_BIT] = ^{f[STATUS_BIT], f[OCD_BIT:0]};
    return f;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for an asynchronous SPI line plus rise/fall edge detection.
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/tli4970_emulator.sv
// TLI4970 current-sensor emulator: SPI slave that shifts a 16-bit data or status frame out on MISO.
module tli4970_emulator
  import tli4970_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned OFFSET      = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] current_in,
  input  logic               current_valid,
  input  logic               status_req,
  input  logic [12:0]        status_bits,
  input  logic               spi_cs,
  input  logic               spi_clk,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  output logic               frame_done,
  output logic               frame_aborted
);

  logic cs_level_unused, cs_rise_s, cs_fall_s;
  logic sclk_level_unused, sclk_rise_unused, sclk_fall_s;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_cs),
    .level_o (cs_level_unused),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_clk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise_unused),
    .fall_o  (sclk_fall_s)
  );

  state_e               state_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [3:0]           idx_q;
  logic signed [15:0]   hold_q;
  logic                 pend_q;
  logic                 miso_q, oe_q, done_q, abort_q;
  logic [FRAME_W-1:0]   frame_s;

  // Built from the pre-update hold value so a same-cycle current_valid goes to the next frame.
  assign frame_s = build_frame(pend_q, hold_q, status_bits, RAW_W'(OFFSET));

  // Frame sequencer with hold register, pending-status flag and registered SPI outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= 4'd0;
      hold_q  <= 16'sd0;
      pend_q  <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (current_valid) hold_q <= current_in;
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            frame_q <= frame_s;
            miso_q  <= frame_s[FRAME_W-1];
            idx_q   <= 4'd15;
            oe_q    <= 1'b1;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise_s) begin
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_fall_s) begin
            if (idx_q != 4'd0) begin
              idx_q  <= idx_q - 4'd1;
              miso_q <= frame_q[idx_q - 4'd1];
            end else begin
              miso_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          if (cs_rise_s) begin
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          miso_q  <= 1'b0;
          oe_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // A request arriving with the frame-start edge survives the clear above.
      if (status_req) pend_q <= 1'b1;
    end
  end

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = oe_q;
  assign frame_done    = done_q;
  assign frame_aborted = abort_q;

endmodule

// File: tb/tb_tli4970_emulator.sv
// Scoreboard bench: an SPI master drives reads, a monitor captures MISO and checks each finished frame.
module tb_tli4970_emulator;

  localparam int SYNC  = 2;
  localparam int PHASE = 18;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] current_in = 16'sd0;
  logic               current_valid = 1'b0;
  logic               status_req = 1'b0;
  logic [12:0]        status_bits = 13'd0;
  logic               spi_cs = 1'b1;
  logic               spi_clk = 1'b0;
  logic               spi_miso, spi_miso_oe, frame_done, frame_aborted;

  tli4970_emulator #(.SYNC_STAGES(SYNC), .OFFSET(4096)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .current_in    (current_in),
    .current_valid (current_valid),
    .status_req    (status_req),
    .status_bits   (status_bits),
    .spi_cs        (spi_cs),
    .spi_clk       (spi_clk),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    bit          abort;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_hold = 0;
  bit          m_pend = 1'b0;
  logic [15:0] mon_sr = 16'h0000;

  // Sensor rules in plain integer arithmetic.
  function automatic logic [15:0] model_frame(bit is_status, int cur, int sbits);
    int c, w, ones;
    bit ocd;
    if (is_status) begin
      w = 32768 + sbits;
    end else begin
      c = cur;
      ocd = 1'b0;
      if (c > 4095) begin c = 4095; ocd = 1'b1; end
      if (c < -4096) begin c = -4096; ocd = 1'b1; end
      w = (ocd ? 8192 : 0) + (c + 4096);
    end
    ones = 0;
    for (int b = 0; b < 16; b++) ones += (w >> b) & 1;
    if (ones % 2 == 1) w += 16384;
    return 16'(w);
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge spi_clk) mon_sr <= {mon_sr[14:0], spi_miso};

  // Monitor: every done/aborted pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && (frame_done || frame_aborted)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: done=%b aborted=%b with no frame outstanding", frame_done, frame_aborted);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.abort) begin
          if (!(frame_aborted && !frame_done)) begin
            errors++;
            $display("FAIL abort_pulse: done=%b aborted=%b expected aborted only", frame_done, frame_aborted);
          end
        end else if (!(frame_done && !frame_aborted) || mon_sr !== e.frame) begin
          errors++;
          $display("FAIL frame: got %h (done=%b aborted=%b) expected %h", mon_sr, frame_done, frame_aborted, e.frame);
        end
      end
    end
  end

  task automatic wait_clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_current(int v);
    @(negedge clk);
    current_in = 16'(v);
    current_valid = 1'b1;
    @(negedge clk);
    current_valid = 1'b0;
    m_hold = v;
  endtask

  task automatic req_status(int bits);
    @(negedge clk);
    status_bits = 13'(bits);
    status_req = 1'b1;
    @(negedge clk);
    status_req = 1'b0;
    m_pend = 1'b1;
  endtask

  // One master read; forced >= 0 replaces the model with a literal expected frame.
  task automatic read_frame(int n_falls, int forced, bit co_valid, int co_val, bit co_status);
    exp_t e;
    e.frame = (forced >= 0) ? 16'(forced) : model_frame(m_pend, m_hold, int'(status_bits));
    e.abort = (n_falls < 16);
    exp_q.push_back(e);
    m_pend = 1'b0;
    @(negedge clk);
    spi_cs = 1'b0;
    if (co_valid || co_status) begin
      wait_clks(SYNC);
      current_in = 16'(co_val);
      current_valid = co_valid;
      status_req = co_status;
      @(negedge clk);
      current_valid = 1'b0;
      status_req = 1'b0;
      if (co_valid) m_hold = co_val;
      if (co_status) m_pend = 1'b1;
    end
    wait_clks(PHASE);
    check("oe_during_frame", {15'd0, spi_miso_oe}, 16'd1);
    for (int i = 0; i < n_falls; i++) begin
      spi_clk = 1'b1;
      wait_clks(PHASE);
      spi_clk = 1'b0;
      wait_clks(PHASE);
    end
    spi_cs = 1'b1;
    wait_clks(PHASE + 2);
    check("oe_after_cs_rise", {15'd0, spi_miso_oe}, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clks(3);
    check("rst_miso", {15'd0, spi_miso}, 16'd0);
    check("rst_oe", {15'd0, spi_miso_oe}, 16'd0);
    check("rst_done", {15'd0, frame_done}, 16'd0);
    check("rst_aborted", {15'd0, frame_aborted}, 16'd0);
    rst_n = 1'b1;
    wait_clks(5);

    load_current(0);      read_frame(16, 'h5000, 0, 0, 0);
    load_current(100);    read_frame(16, 'h1064, 0, 0, 0);
    load_current(-4096);  read_frame(16, 'h0000, 0, 0, 0);
    load_current(5000);   read_frame(16, 'h3FFF, 0, 0, 0);
    req_status(5);        read_frame(16, 'hC005, 0, 0, 0);
    read_frame(16, 'h3FFF, 0, 0, 0);
    read_frame(7, -1, 0, 0, 0);
    read_frame(16, 'h3FFF, 0, 0, 0);
    // Coincident strobes: frame keeps old hold, status goes to the next frame.
    load_current(100);
    read_frame(16, 'h1064, 1, -4096, 1);
    read_frame(16, 'hC005, 0, 0, 0);
    read_frame(16, 'h0000, 0, 0, 0);

    for (int it = 0; it < 20; it++) begin
      load_current(int'($urandom_range(0, 12000)) - 6000);
      if ($urandom_range(0, 3) == 0) req_status(int'($urandom_range(0, 8191)));
      read_frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16, -1, 0, 0, 0);
    end

    // Reset in the middle of a frame.
    load_current(1234);
    @(negedge clk);
    spi_cs = 1'b0;
    wait_clks(PHASE);
    for (int i = 0; i < 5; i++) begin
      spi_clk = 1'b1;
      wait_clks(PHASE);
      spi_clk = 1'b0;
      wait_clks(PHASE);
    end
    check("oe_before_reset", {15'd0, spi_miso_oe}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", {15'd0, spi_miso}, 16'd0);
    check("midrst_oe", {15'd0, spi_miso_oe}, 16'd0);
    check("midrst_done", {15'd0, frame_done}, 16'd0);
    check("midrst_aborted", {15'd0, frame_aborted}, 16'd0);
    m_hold = 0;
    m_pend = 1'b0;
    @(negedge clk);
    spi_cs = 1'b1;
    spi_clk = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    read_frame(16, 'h5000, 0, 0, 0);

    wait_clks(50);
    check("outstanding_frames", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
